// File: rtl/pistorm_pkg.sv
// pistorm_pkg: shared arbiter state encoding, parameter defaults and status bit positions
package pistorm_pkg;
  typedef enum logic [2:0] {
    RST_HOLD, IDLE, PI_CYCLE, PI_FIRST, GRANT_PEND, DMA_OWNED, RELEASE
  } arb_state_t;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int GRANT_TIMEOUT_DEF = 64;
  localparam int STAT_DMA_ACTIVE_BIT = 0;
  localparam int STAT_GRANT_ERR_BIT = 1;
  function automatic logic [7:0] status_bits(logic dma_active, logic grant_err);
    status_bits = '0;
    status_bits[STAT_DMA_ACTIVE_BIT] = dma_active;
    status_bits[STAT_GRANT_ERR_BIT] = grant_err;
  endfunction
endpackage

// File: rtl/m68k_bus_arbiter_if.sv
// m68k_bus_arbiter_if: 68000 BR/BG/BGACK wires plus the Pi engine handshake and status
interface m68k_bus_arbiter_if;
  logic BR_n, BGACK_n, BG_n;
  logic cyc_req, cyc_gnt, cyc_done;
  logic drive_en, dma_active, grant_err, err_clr;
  modport master (
    input BR_n, BGACK_n, cyc_req, cyc_done, err_clr,
    output BG_n, cyc_gnt, drive_en, dma_active, grant_err
  );
  modport slave (
    output BR_n, BGACK_n, cyc_req, cyc_done, err_clr,
    input BG_n, cyc_gnt, drive_en, dma_active, grant_err
  );
endinterface

// File: rtl/pistorm_sync.sv
// pistorm_sync: N-stage synchronizer whose stages preset to RST_VAL on async reset
module pistorm_sync #(
  parameter int N = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [N-1:0] s;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) s <= {N{RST_VAL}};
    else s <= {s[N-2:0], d};
  assign q = s[N-1];
endmodule

// File: rtl/m68k_bus_arbiter.sv
// m68k_bus_arbiter: synchronous BR/BG/BGACK arbiter between the Pi engine and DMA masters
module m68k_bus_arbiter
  import pistorm_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int GRANT_TIMEOUT = GRANT_TIMEOUT_DEF,
  parameter logic BG_EARLY = 1'b1
) (
  input logic M68K_CLK,
  input logic M68K_RESET_n,
  m68k_bus_arbiter_if.master bus
);
  arb_state_t state;
  logic br_s, bgack_s, brq, bgack, lock, grant, timeout;
  logic bg_n, drive_en, cyc_gnt, dma_active, grant_err;
  logic [7:0] cnt;
  pistorm_sync #(.N(SYNC_STAGES), .RST_VAL(1'b1)) u_br_sync (
    .clk(M68K_CLK), .rst_n(M68K_RESET_n), .d(bus.BR_n), .q(br_s)
  );
  pistorm_sync #(.N(SYNC_STAGES), .RST_VAL(1'b1)) u_bgack_sync (
    .clk(M68K_CLK), .rst_n(M68K_RESET_n), .d(bus.BGACK_n), .q(bgack_s)
  );
  assign brq = !br_s;
  assign bgack = !bgack_s;
  // after a timeout no grant is issued until BR has been seen negated
  assign grant = brq && !lock;
  assign timeout = cnt == 8'(GRANT_TIMEOUT - 1);
  always_ff @(posedge M68K_CLK or negedge M68K_RESET_n)
    if (!M68K_RESET_n) begin
      state <= RST_HOLD;
      cnt <= '0;
      lock <= 1'b0;
      bg_n <= 1'b1;
      drive_en <= 1'b0;
      cyc_gnt <= 1'b0;
      dma_active <= 1'b0;
      grant_err <= 1'b0;
    end else begin
      if (!brq) lock <= 1'b0;
      if (bus.err_clr) grant_err <= 1'b0;
      case (state)
        RST_HOLD: begin
          state <= IDLE;
          drive_en <= 1'b1;
        end
        IDLE:
          if (grant) begin
            state <= GRANT_PEND;
            bg_n <= 1'b0;
            drive_en <= 1'b0;
            cnt <= '0;
          end else if (bus.cyc_req) begin
            state <= PI_CYCLE;
            cyc_gnt <= 1'b1;
          end
        PI_CYCLE, PI_FIRST:
          if (bus.cyc_done) begin
            cyc_gnt <= 1'b0;
            state <= grant ? GRANT_PEND : IDLE;
            bg_n <= !grant;
            drive_en <= !grant;
            cnt <= '0;
          end else bg_n <= !(BG_EARLY && state == PI_CYCLE && grant);
        GRANT_PEND: begin
          cnt <= (cnt == 8'hFF) ? cnt : cnt + 8'd1;
          if (bgack) begin
            state <= DMA_OWNED;
            bg_n <= 1'b1;
            dma_active <= 1'b1;
          end else if (!brq || timeout) begin
            state <= IDLE;
            bg_n <= 1'b1;
            drive_en <= 1'b1;
            grant_err <= timeout && brq ? 1'b1 : (bus.err_clr ? 1'b0 : grant_err);
            lock <= brq;
          end
        end
        DMA_OWNED:
          if (!bgack) begin
            state <= RELEASE;
            dma_active <= 1'b0;
          end
        RELEASE: begin
          drive_en <= 1'b1;
          state <= bus.cyc_req ? PI_FIRST : IDLE;
          cyc_gnt <= bus.cyc_req;
        end
        default: state <= RST_HOLD;
      endcase
    end
  assign bus.BG_n = bg_n;
  assign bus.drive_en = drive_en;
  assign bus.cyc_gnt = cyc_gnt;
  assign bus.dma_active = dma_active;
  assign bus.grant_err = grant_err;
endmodule

// File: tb/tb_m68k_bus_arbiter.sv
// tb_m68k_bus_arbiter: scenario tests with randomized durations; expected timing derived from the arbitration rules
module tb_m68k_bus_arbiter;
  logic clk = 1'b0, rst_n = 1'b1;
  logic br_n = 1'b1, bgack_n = 1'b1, cyc_req = 1'b0, cyc_done = 1'b0, err_clr = 1'b0;
  int checks = 0, fails = 0;
  always #5 clk = ~clk;
  m68k_bus_arbiter_if ife ();
  m68k_bus_arbiter_if ifl ();
  assign ife.BR_n = br_n;
  assign ife.BGACK_n = bgack_n;
  assign ife.cyc_req = cyc_req;
  assign ife.cyc_done = cyc_done;
  assign ife.err_clr = err_clr;
  assign ifl.BR_n = br_n;
  assign ifl.BGACK_n = bgack_n;
  assign ifl.cyc_req = cyc_req;
  assign ifl.cyc_done = cyc_done;
  assign ifl.err_clr = err_clr;
  m68k_bus_arbiter #(.SYNC_STAGES(2), .GRANT_TIMEOUT(8), .BG_EARLY(1'b1)) dut_e (
    .M68K_CLK(clk), .M68K_RESET_n(rst_n), .bus(ife)
  );
  m68k_bus_arbiter #(.SYNC_STAGES(2), .GRANT_TIMEOUT(8), .BG_EARLY(1'b0)) dut_l (
    .M68K_CLK(clk), .M68K_RESET_n(rst_n), .bus(ifl)
  );
  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    logic [4:0] got;
    #1 rst_n = 1'b0;
    #1 got = {ife.BG_n, ife.drive_en, ife.cyc_gnt, ife.dma_active, ife.grant_err};
    checks++;
    if (got !== 5'b10000) begin fails++; $display("FAIL reset_values: got %b want 10000", got); end
    tick(1);
    rst_n = 1'b1;
    checks++;
    if (ife.drive_en !== 1'b0) begin fails++; $display("FAIL rst_hold_drive: got %b want 0", ife.drive_en); end
    tick(1);
    got = {ife.BG_n, ife.drive_en, ife.cyc_gnt, 2'b00};
    checks++;
    if (got !== 5'b11000) begin fails++; $display("FAIL reset_to_idle: got %b want 11000", got); end
  endtask
  task automatic test_idle_grant();
    int hold = $urandom_range(4, 20);
    br_n = 1'b0;
    tick(2);
    checks++;
    if (ife.BG_n !== 1'b1) begin fails++; $display("FAIL grant_latency_early: got %b want 1", ife.BG_n); end
    tick(1);
    checks++;
    if ({ife.BG_n, ife.drive_en} !== 2'b00) begin fails++; $display("FAIL idle_grant: got %b want 00", {ife.BG_n, ife.drive_en}); end
    tick(2);
    bgack_n = 1'b0;
    br_n = 1'b1;
    tick(2);
    checks++;
    if (ife.BG_n !== 1'b0) begin fails++; $display("FAIL bgack_latency: got %b want 0", ife.BG_n); end
    tick(1);
    checks++;
    if ({ife.BG_n, ife.dma_active, ife.drive_en} !== 3'b110) begin fails++; $display("FAIL dma_owned: got %b want 110", {ife.BG_n, ife.dma_active, ife.drive_en}); end
    br_n = 1'b0;
    tick(hold);
    checks++;
    if ({ife.BG_n, ife.dma_active} !== 2'b11) begin fails++; $display("FAIL br_during_dma: got %b want 11", {ife.BG_n, ife.dma_active}); end
    bgack_n = 1'b1;
    br_n = 1'b1;
    tick(2);
    checks++;
    if (ife.dma_active !== 1'b1) begin fails++; $display("FAIL dma_hold: got %b want 1", ife.dma_active); end
    tick(1);
    checks++;
    if ({ife.drive_en, ife.dma_active} !== 2'b00) begin fails++; $display("FAIL release: got %b want 00", {ife.drive_en, ife.dma_active}); end
    tick(1);
    checks++;
    if ({ife.drive_en, ife.BG_n} !== 2'b11) begin fails++; $display("FAIL release_to_idle: got %b want 11", {ife.drive_en, ife.BG_n}); end
  endtask
  task automatic test_mid_cycle();
    int w = $urandom_range(0, 5);
    cyc_req = 1'b1;
    tick(1);
    checks++;
    if ({ife.cyc_gnt, ifl.cyc_gnt} !== 2'b11) begin fails++; $display("FAIL pi_cycle_gnt: got %b want 11", {ife.cyc_gnt, ifl.cyc_gnt}); end
    br_n = 1'b0;
    tick(3);
    checks++;
    if ({ife.BG_n, ife.drive_en, ife.cyc_gnt} !== 3'b011) begin fails++; $display("FAIL bg_early: got %b want 011", {ife.BG_n, ife.drive_en, ife.cyc_gnt}); end
    checks++;
    if ({ifl.BG_n, ifl.drive_en, ifl.cyc_gnt} !== 3'b111) begin fails++; $display("FAIL bg_late: got %b want 111", {ifl.BG_n, ifl.drive_en, ifl.cyc_gnt}); end
    tick(w);
    checks++;
    if ({ife.BG_n, ife.drive_en, ifl.BG_n} !== 3'b011) begin fails++; $display("FAIL mid_cycle_hold: got %b want 011", {ife.BG_n, ife.drive_en, ifl.BG_n}); end
    cyc_done = 1'b1;
    cyc_req = 1'b0;
    tick(1);
    cyc_done = 1'b0;
    checks++;
    if ({ife.BG_n, ife.drive_en, ife.cyc_gnt, ifl.BG_n, ifl.drive_en, ifl.cyc_gnt} !== 6'b000000) begin
      fails++; $display("FAIL after_cyc_done: got %b want 000000", {ife.BG_n, ife.drive_en, ife.cyc_gnt, ifl.BG_n, ifl.drive_en, ifl.cyc_gnt});
    end
    br_n = 1'b1;
    tick(3);
    checks++;
    if ({ife.BG_n, ife.drive_en, ifl.BG_n, ifl.drive_en, ife.grant_err} !== 5'b11110) begin
      fails++; $display("FAIL mid_cycle_withdraw: got %b want 11110", {ife.BG_n, ife.drive_en, ifl.BG_n, ifl.drive_en, ife.grant_err});
    end
  endtask
  task automatic test_withdrawn();
    int len = $urandom_range(1, 7);
    logic exp;
    br_n = 1'b0;
    for (int i = 1; i <= len + 3; i++) begin
      tick(1);
      exp = (i >= 3 && i <= len + 2) ? 1'b0 : 1'b1;
      checks++;
      if (ife.BG_n !== exp) begin fails++; $display("FAIL withdrawn_bg clk%0d len%0d: got %b want %b", i, len, ife.BG_n, exp); end
      if (i == len) br_n = 1'b1;
    end
    checks++;
    if ({ife.grant_err, ife.drive_en, ife.cyc_gnt} !== 3'b010) begin fails++; $display("FAIL withdrawn_idle: got %b want 010", {ife.grant_err, ife.drive_en, ife.cyc_gnt}); end
  endtask
  task automatic test_timeout();
    int r = $urandom_range(2, 10);
    logic exp;
    br_n = 1'b0;
    for (int i = 1; i <= 11; i++) begin
      tick(1);
      exp = (i >= 3 && i <= 10) ? 1'b0 : 1'b1;
      checks++;
      if (ife.BG_n !== exp) begin fails++; $display("FAIL timeout_bg clk%0d: got %b want %b", i, ife.BG_n, exp); end
      if (i == 10) begin
        checks++;
        if (ife.grant_err !== 1'b0) begin fails++; $display("FAIL timeout_err_early: got %b want 0", ife.grant_err); end
      end
      err_clr = (i == 10);
    end
    checks++;
    if ({ife.grant_err, ifl.grant_err} !== 2'b11) begin fails++; $display("FAIL timeout_set_wins: got %b want 11", {ife.grant_err, ifl.grant_err}); end
    for (int i = 0; i < r; i++) begin
      tick(1);
      checks++;
      if ({ife.BG_n, ife.drive_en} !== 2'b11) begin fails++; $display("FAIL lockout clk%0d: got %b want 11", i, {ife.BG_n, ife.drive_en}); end
    end
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    checks++;
    if (ife.grant_err !== 1'b0) begin fails++; $display("FAIL err_clr: got %b want 0", ife.grant_err); end
    br_n = 1'b1;
    tick(1);
    br_n = 1'b0;
    tick(2);
    checks++;
    if (ife.BG_n !== 1'b1) begin fails++; $display("FAIL relock_early: got %b want 1", ife.BG_n); end
    tick(1);
    checks++;
    if (ife.BG_n !== 1'b0) begin fails++; $display("FAIL regrant_after_negate: got %b want 0", ife.BG_n); end
    br_n = 1'b1;
    tick(3);
    checks++;
    if ({ife.BG_n, ife.drive_en, ife.grant_err} !== 3'b110) begin fails++; $display("FAIL timeout_cleanup: got %b want 110", {ife.BG_n, ife.drive_en, ife.grant_err}); end
  endtask
  task automatic test_back_to_back();
    int n = $urandom_range(2, 4);
    cyc_done = 1'b1;
    tick(1);
    cyc_done = 1'b0;
    checks++;
    if ({ife.cyc_gnt, ife.drive_en} !== 2'b01) begin fails++; $display("FAIL done_in_idle: got %b want 01", {ife.cyc_gnt, ife.drive_en}); end
    cyc_req = 1'b1;
    for (int k = 0; k < n; k++) begin
      tick(1);
      checks++;
      if (ife.cyc_gnt !== 1'b1) begin fails++; $display("FAIL b2b_gnt%0d: got %b want 1", k, ife.cyc_gnt); end
      tick($urandom_range(0, 3));
      cyc_done = 1'b1;
      if (k == n - 1) cyc_req = 1'b0;
      tick(1);
      cyc_done = 1'b0;
      checks++;
      if (ife.cyc_gnt !== 1'b0) begin fails++; $display("FAIL b2b_idle%0d: got %b want 0", k, ife.cyc_gnt); end
    end
    tick(1);
    checks++;
    if ({ife.cyc_gnt, ife.drive_en} !== 2'b01) begin fails++; $display("FAIL b2b_end: got %b want 01", {ife.cyc_gnt, ife.drive_en}); end
  endtask
  task automatic test_starvation();
    int hold = $urandom_range(3, 10);
    int len = $urandom_range(1, 6);
    br_n = 1'b0;
    tick(3);
    bgack_n = 1'b0;
    br_n = 1'b1;
    tick(3);
    checks++;
    if (ife.dma_active !== 1'b1) begin fails++; $display("FAIL starve_dma1: got %b want 1", ife.dma_active); end
    cyc_req = 1'b1;
    tick(hold);
    bgack_n = 1'b1;
    br_n = 1'b0;
    tick(3);
    checks++;
    if ({ife.dma_active, ife.drive_en, ife.cyc_gnt} !== 3'b000) begin fails++; $display("FAIL starve_release: got %b want 000", {ife.dma_active, ife.drive_en, ife.cyc_gnt}); end
    tick(1);
    checks++;
    if ({ife.BG_n, ife.drive_en, ife.cyc_gnt} !== 3'b111) begin fails++; $display("FAIL pi_first: got %b want 111", {ife.BG_n, ife.drive_en, ife.cyc_gnt}); end
    for (int i = 0; i < len; i++) begin
      tick(1);
      checks++;
      if ({ife.BG_n, ife.cyc_gnt, ifl.BG_n, ifl.cyc_gnt} !== 4'b1111) begin
        fails++; $display("FAIL pi_first_hold%0d: got %b want 1111", i, {ife.BG_n, ife.cyc_gnt, ifl.BG_n, ifl.cyc_gnt});
      end
    end
    cyc_done = 1'b1;
    tick(1);
    cyc_done = 1'b0;
    checks++;
    if ({ife.BG_n, ife.cyc_gnt, ife.drive_en} !== 3'b000) begin fails++; $display("FAIL starve_grant: got %b want 000", {ife.BG_n, ife.cyc_gnt, ife.drive_en}); end
    bgack_n = 1'b0;
    br_n = 1'b1;
    tick(3);
    checks++;
    if (ife.dma_active !== 1'b1) begin fails++; $display("FAIL starve_dma2: got %b want 1", ife.dma_active); end
    bgack_n = 1'b1;
    tick(4);
    checks++;
    if (ife.cyc_gnt !== 1'b1) begin fails++; $display("FAIL starve_pi2: got %b want 1", ife.cyc_gnt); end
    cyc_done = 1'b1;
    cyc_req = 1'b0;
    tick(1);
    cyc_done = 1'b0;
    checks++;
    if ({ife.cyc_gnt, ife.BG_n, ife.drive_en} !== 3'b011) begin fails++; $display("FAIL starve_end: got %b want 011", {ife.cyc_gnt, ife.BG_n, ife.drive_en}); end
  endtask
  task automatic test_reset_mid_dma();
    logic [4:0] got;
    cyc_req = 1'b1;
    tick(1);
    #2 rst_n = 1'b0;
    cyc_req = 1'b0;
    #1 checks++;
    if (ife.cyc_gnt !== 1'b0) begin fails++; $display("FAIL reset_mid_pi: got %b want 0", ife.cyc_gnt); end
    tick(1);
    rst_n = 1'b1;
    tick(1);
    br_n = 1'b0;
    tick(3);
    bgack_n = 1'b0;
    br_n = 1'b1;
    tick(3);
    checks++;
    if (ife.dma_active !== 1'b1) begin fails++; $display("FAIL reset_dma_setup: got %b want 1", ife.dma_active); end
    #2 rst_n = 1'b0;
    bgack_n = 1'b1;
    #1 got = {ife.BG_n, ife.drive_en, ife.dma_active, ife.cyc_gnt, ife.grant_err};
    checks++;
    if (got !== 5'b10000) begin fails++; $display("FAIL reset_mid_dma: got %b want 10000", got); end
    tick(2);
    rst_n = 1'b1;
    checks++;
    if (ife.drive_en !== 1'b0) begin fails++; $display("FAIL reset_exit_hold: got %b want 0", ife.drive_en); end
    tick(1);
    checks++;
    if ({ife.BG_n, ife.drive_en, ife.dma_active} !== 3'b110) begin fails++; $display("FAIL reset_exit_idle: got %b want 110", {ife.BG_n, ife.drive_en, ife.dma_active}); end
  endtask
  initial begin
    test_reset();
    test_idle_grant();
    test_mid_cycle();
    test_withdrawn();
    test_timeout();
    test_back_to_back();
    test_starvation();
    test_reset_mid_dma();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/m68k_bus_arbiter.md
Name: m68k_bus_arbiter

Overview:
- Owns the 68000 three-wire bus arbitration (BR/BG/BGACK) for the PiStorm'X CPLD.
- Decides cycle-by-cycle whether the Pi transaction engine or an external DMA master (Agnus, Zorro cards) owns the Amiga bus.
- Gates the start of Pi bus cycles, asserts BG only at a legal boundary and tri-states all PiStorm bus drivers while DMA owns the bus.
- Replaces the ad-hoc asynchronous grant latch with a synchronous FSM that has anti-lockup and anti-starvation rules.

Parameters:
- SYNC_STAGES, 2, synchronizer depth for BR_n and BGACK_n (minimum 2).
- GRANT_TIMEOUT, 64, clocks to wait for BGACK after BG before withdrawing the grant (minimum 4).
- BG_EARLY, 1: 1 = BG_n may assert during an active Pi cycle; 0 = BG_n asserts only after cyc_done.

Ports:
- M68K_CLK  in  1  7 MHz bus clock; all logic on the rising edge.
- M68K_RESET_n  in  1  asynchronous active-low reset.
- BR_n  in  1  bus request, asynchronous, from the Amiga bus.
- BGACK_n  in  1  bus grant acknowledge, asynchronous, from the Amiga bus.
- cyc_req  in  1  level; the transaction engine has a pending bus cycle.
- cyc_gnt  out  1  level; the engine may start or continue a cycle.
- cyc_done  in  1  one-clock pulse at the end of S7 of a Pi cycle.
- BG_n  out  1  bus grant to the Amiga bus.
- drive_en  out  1  1 = PiStorm drives A/D/AS/UDS/LDS/RW/VMA; 0 = all tri-stated.
- dma_active  out  1  status bit for the Pi status register.
- grant_err  out  1  sticky; a grant timed out.
- err_clr  in  1  one-clock pulse; clears grant_err.

Behaviour:
- Reset values: BG_n=1, drive_en=0, cyc_gnt=0, dma_active=0, grant_err=0. FSM=RST_HOLD, counter=0. Synchronizers preset to 1 (negated).
- brq = synchronized !BR_n; bgack = synchronized !BGACK_n. Input-to-decision latency is SYNC_STAGES clocks.
- States:
  - RST_HOLD: one clock after reset release, then IDLE. Drivers stay off.
  - IDLE: drive_en=1, strobes inactive.
    - If brq: go to GRANT_PEND. brq beats cyc_req when both are seen in the same clock.
    - Else if cyc_req: go to PI_CYCLE.
  - PI_CYCLE: cyc_gnt=1, drive_en=1.
    - If BG_EARLY=1 and brq, BG_n=0 from the next clock while the cycle finishes.
    - On cyc_done: if brq, go to GRANT_PEND; else go to IDLE.
    - cyc_gnt drops the clock after cyc_done. A still-pending cyc_req re-enters PI_CYCLE via IDLE, which costs 1 idle clock.
  - GRANT_PEND: BG_n=0, drive_en=0, cyc_gnt=0, counter increments.
    - If bgack: go to DMA_OWNED.
    - Else if !brq: BG_n=1 and go to IDLE. This is a request withdrawn before acknowledge; no error.
    - Else if counter==GRANT_TIMEOUT-1: set grant_err, BG_n=1 and go to IDLE. This is anti-lockup; no new grant may be issued until brq has been seen negated for at least 1 clock.
  - DMA_OWNED: BG_n=1 on entry, drive_en=0, dma_active=1.
    - BR re-assertion during DMA_OWNED does not assert BG.
    - When bgack negates, go to RELEASE.
  - RELEASE: one clock, drive_en=0 (bus turnaround).
    - Next state is PI_FIRST if cyc_req, else IDLE.
  - PI_FIRST: identical to PI_CYCLE except brq is ignored for BG until cyc_done. This is anti-starvation: one Pi cycle is guaranteed between DMA tenures.
- drive_en changes only at FSM transitions. It must never be 1 in any clock where BG_n=0 and bgack=1.
- Counter is 8 bits; it saturates and is cleared on every GRANT_PEND entry.
- err_clr and a simultaneous timeout: set wins.
- Reset mid-operation: everything returns to reset values asynchronously. BG_n negates immediately and the drivers tri-state. An interrupted Pi cycle is abandoned; the engine sees cyc_gnt=0.
- cyc_done outside PI_CYCLE/PI_FIRST is ignored.

Decomposition:
- Shared package pistorm_pkg holds:
  - state encoding enum arb_state_t (RST_HOLD, IDLE, PI_CYCLE, PI_FIRST, GRANT_PEND, DMA_OWNED, RELEASE);
  - GRANT_TIMEOUT and SYNC_STAGES defaults;
  - the status-register bit positions for dma_active and grant_err.
- One sub-module: pistorm_sync, a parameterized N-stage synchronizer with reset preset value. It is instantiated twice, for BR_n and BGACK_n.

Test Plan:
- Idle grant:
  - Stimulus: BR_n low at clock 0, no cyc_req.
  - Required: BG_n=0 and drive_en=0 at clock 3 (SYNC_STAGES=2). BGACK_n low at clock 5 gives BG_n=1 at clock 8 and dma_active=1.
  - Then: BGACK_n high gives drive_en=1 exactly 1 RELEASE clock after the state leaves DMA_OWNED.
- Mid-cycle request:
  - Stimulus: cyc_req held, BR_n low during PI_CYCLE, BG_EARLY=1.
  - Required: BG_n=0 before cyc_done, drive_en stays 1 until cyc_done, then drive_en=0 the next clock. With BG_EARLY=0, BG_n stays 1 until after cyc_done.
- Withdrawn request: BR_n pulses low for 4 clocks with no BGACK -> BG_n returns to 1, state IDLE, grant_err=0.
- Timeout: BR_n held low with no BGACK and GRANT_TIMEOUT=8 -> BG_n=1 after 8 GRANT_PEND clocks and grant_err=1. No new BG until BR_n goes high; err_clr clears grant_err.
- Starvation:
  - Stimulus: BR_n re-asserted immediately after BGACK negates, with cyc_req=1.
  - Required: exactly one Pi cycle (cyc_gnt high until cyc_done) precedes the next BG_n=0.
- Reset mid-DMA: M68K_RESET_n low during DMA_OWNED -> BG_n=1, drive_en=0, dma_active=0 with no clock edge required. Exit goes through RST_HOLD to IDLE.
